mult_rr_sched: RTL and testbench
================================

# mult_rr_sched

Round-robin scheduler that shares one sequential 8x8 shift-add multiplier among `N_REQ` requesters. It arbitrates pending requests, latches the winner's operands, and drives the multiplier's start/busy handshake. It returns the 16-bit product with a one-cycle acknowledge pulse to the winning requester. It sits between the requesting datapath blocks and the single multiplier instance.

## Interface
- `N_REQ`, default 4: number of requesters; legal range 2..8.
- `BUSY_TO`, default 4: number of cycles to wait for `mult_busy_i` to rise after start before flagging an error.
- `clk_i` input 1: clock.
- `rst_i` input 1: reset. One clock; reset is synchronous and active-high.
- `req_bi` input N_REQ: per-requester request level.
- `a_bi` input 8*N_REQ: operand A. Requester i uses bits [8i+7:8i].
- `b_bi` input 8*N_REQ: operand B, same packing as `a_bi`.
- `ack_bo` output N_REQ: one-hot, single-cycle pulse to the served requester.
- `y_bo` output 16: product. Valid only while `ack_bo` is nonzero; holds its value otherwise.
- `busy_o` output 1: scheduler is not in IDLE.
- `err_o` output 1: sticky flag; set on busy timeout, cleared only by reset.
- `mult_start_o` output 1: registered start pulse to the multiplier.
- `mult_a_bo` output 8: operand A to the multiplier. Stable from ISSUE through WAIT_DONE.
- `mult_b_bo` output 8: operand B to the multiplier, same stability as `mult_a_bo`.
- `mult_y_bi` input 16: multiplier product.
- `mult_busy_i` input 1: multiplier busy.

## Operation
- **Reset values:**
  - `ack_bo`=0, `y_bo`=0, `busy_o`=0, `err_o`=0, `mult_start_o`=0, `mult_a_bo`=0, `mult_b_bo`=0.
  - State = IDLE; last-grant pointer = N_REQ-1, so requester 0 wins first.
- **Requester rules:**
  - A requester holds `req` high and its operands stable until it sees its `ack` bit.
  - A `req` still high in the cycle after `ack` counts as a new request.
- **Arbitration:**
  - Search `req_bi` from `ptr+1` upward, wrapping modulo N_REQ.
  - The first set bit wins, and `ptr` becomes the winner.
  - Arbitration happens only in IDLE. Requests arriving during service wait.
- **States:**
  - IDLE: if any `req` is set, latch the winner id and its operands, drive `mult_start_o`=1, and go to ISSUE.
  - ISSUE (1 cycle): `mult_start_o` stays 1 this cycle and drops to 0 on exit. Go to WAIT_BUSY.
  - WAIT_BUSY: if `mult_busy_i`=1, go to WAIT_DONE.
    - Otherwise increment the timeout counter.
    - When the counter reaches `BUSY_TO`, set `err_o`, do not ack, and return to IDLE. `ptr` still advances.
  - WAIT_DONE: if `mult_busy_i`=0, register `y_bo` from `mult_y_bi`, set `ack_bo[id]`=1, and go to RESP.
  - RESP (1 cycle): clear `ack_bo` on exit and go to IDLE.
- **Widths:** operands are 8-bit unsigned; the product is 16-bit unsigned and passes through unmodified.
- **Reset mid-operation:** any state returns to IDLE on the next edge. No ack is issued, and the in-flight request is dropped. The shared multiplier is reset by the same `rst_i`.
- **Requester withdrawal:** a requester dropping `req` mid-service still receives its `ack`. The result is discarded by that requester.

## Timing
- Edge k: IDLE samples `req`. `mult_start_o`=1 from k to k+1.
- Edge k+1: the multiplier samples start, and `mult_busy_i` rises.
- Edge k+2: the scheduler enters WAIT_DONE.
- The 8x8 multiplier deasserts busy after edge k+10.
- Edge k+11: the scheduler enters RESP. `ack_bo`/`y_bo` are valid in the cycle after k+11.
- Latency from request sample to ack is 11 edges; service throughput is 13 cycles per operation including RESP and IDLE.
- `busy_o` is 1 from edge k through the RESP cycle inclusive.
- `mult_start_o` is never high for more than one multiplier-sampled cycle per operation.

## Structure
- Shared package `mult_pkg` holds:
  - `OP_W`=8 and `RES_W`=16.
  - The state enum: IDLE, ISSUE, WAIT_BUSY, WAIT_DONE, RESP.
  - The default `BUSY_TO`.
- Sub-module `rr_pick`: a combinational round-robin picker.
  - Inputs: `req` vector and `ptr`.
  - Outputs: `valid` and winner index.
  - Reused by other shared-resource schedulers.
- The multiplier is external; the bench instantiates it alongside the scheduler.

## Test plan
- **Single request:** requester 2 requests with a=8'd13, b=8'd11 → `ack_bo`=4'b0100 for exactly one cycle, 11 edges after the sample, with `y_bo`=16'd143.
- **All four requesting from reset:** 4'b1111 held and re-asserted continuously → service order 0,1,2,3,0. Each ack is one-hot, and there are 13 cycles between acks.
- **Corner operands:** a=8'hFF, b=8'hFF → `y_bo`=16'hFE01. a=0, b=8'hA5 → `y_bo`=0.
- **Wrap-around:** serve requester 3 with requester 1 pending, then raise requester 0 during service → requester 0 is served before requester 1.
- **Reset mid-operation:** assert `rst_i` for one cycle during WAIT_DONE → no ack, all outputs at reset values, and the next request is served normally by requester 0 priority.
- **Busy timeout:** stub `mult_busy_i` tied to 0 → `err_o` rises `BUSY_TO`+2 edges after the sample, stays sticky, no ack is issued, and the scheduler returns to IDLE.

Source files
------------

// File: rtl/mult_rr_sched_pkg.sv
// Shared types and constants for the round-robin multiplier scheduler.
// The state enum is also used by anything that binds onto the scheduler FSM.
package mult_pkg;

    localparam int OP_W            = 8;
    localparam int RES_W           = 16;
    localparam int BUSY_TO_DEFAULT = 4;

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        ISSUE     = 3'd1,
        WAIT_BUSY = 3'd2,
        WAIT_DONE = 3'd3,
        RESP      = 3'd4
    } sched_state_e;

endpackage

// File: rtl/mult_rr_sched_rr_pick.sv
// Combinational round-robin picker: first set request strictly after ptr_i,
// wrapping modulo N. Kept generic so other shared-resource schedulers can reuse it.
module rr_pick #(
    parameter int N     = 4,
    parameter int PTR_W = $clog2(N)
) (
    input  logic [N-1:0]     req_i,
    input  logic [PTR_W-1:0] ptr_i,
    output logic             valid_o,
    output logic [PTR_W-1:0] idx_o
);

    logic [PTR_W-1:0] cand;

    // Offsets run 1..N so the previous winner is checked last.
    always_comb begin
        valid_o = 1'b0;
        idx_o   = '0;
        cand    = '0;
        for (int off = 1; off <= N; off++) begin
            cand = PTR_W'((int'(ptr_i) + off) % N);
            if (!valid_o && req_i[cand]) begin
                valid_o = 1'b1;
                idx_o   = cand;
            end
        end
    end

endmodule

// File: rtl/mult_rr_sched.sv
// Shares one sequential multiplier among N_REQ requesters: arbitrates in IDLE,
// drives the start/busy handshake and returns the product with a one-cycle ack.
module mult_rr_sched
    import mult_pkg::*;
#(
    parameter int N_REQ   = 4,
    parameter int BUSY_TO = BUSY_TO_DEFAULT
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic [N_REQ-1:0]      req_bi,
    input  logic [OP_W*N_REQ-1:0] a_bi,
    input  logic [OP_W*N_REQ-1:0] b_bi,
    output logic [N_REQ-1:0]      ack_bo,
    output logic [RES_W-1:0]      y_bo,
    output logic                  busy_o,
    output logic                  err_o,
    output logic                  mult_start_o,
    output logic [OP_W-1:0]       mult_a_bo,
    output logic [OP_W-1:0]       mult_b_bo,
    input  logic [RES_W-1:0]      mult_y_bi,
    input  logic                  mult_busy_i
);

    localparam int PTR_W = $clog2(N_REQ);
    localparam int TO_W  = $clog2(BUSY_TO + 1);
    localparam logic [TO_W-1:0] TO_LIM = TO_W'(BUSY_TO);

    sched_state_e     state_q;
    logic [PTR_W-1:0] ptr_q;
    logic [PTR_W-1:0] id_q;
    logic [OP_W-1:0]  a_q;
    logic [OP_W-1:0]  b_q;
    logic             start_q;
    logic [N_REQ-1:0] ack_q;
    logic [RES_W-1:0] y_q;
    logic             err_q;
    logic [TO_W-1:0]  to_cnt_q;

    logic             pick_valid;
    logic [PTR_W-1:0] pick_idx;
    logic [OP_W-1:0]  pick_a;
    logic [OP_W-1:0]  pick_b;

    rr_pick #(
        .N     (N_REQ),
        .PTR_W (PTR_W)
    ) u_pick (
        .req_i   (req_bi),
        .ptr_i   (ptr_q),
        .valid_o (pick_valid),
        .idx_o   (pick_idx)
    );

    always_comb begin
        pick_a = '0;
        pick_b = '0;
        for (int i = 0; i < N_REQ; i++) begin
            if (pick_idx == PTR_W'(i)) begin
                pick_a = a_bi[i*OP_W +: OP_W];
                pick_b = b_bi[i*OP_W +: OP_W];
            end
        end
    end

    // Operands are latched at grant so the multiplier sees them stable even if
    // the requester withdraws mid-service; that requester still gets its ack.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q  <= IDLE;
            ptr_q    <= PTR_W'(N_REQ - 1);
            id_q     <= '0;
            a_q      <= '0;
            b_q      <= '0;
            start_q  <= 1'b0;
            ack_q    <= '0;
            y_q      <= '0;
            err_q    <= 1'b0;
            to_cnt_q <= '0;
        end else begin
            ack_q <= '0;
            case (state_q)
                IDLE: begin
                    if (pick_valid) begin
                        id_q     <= pick_idx;
                        ptr_q    <= pick_idx;
                        a_q      <= pick_a;
                        b_q      <= pick_b;
                        start_q  <= 1'b1;
                        to_cnt_q <= '0;
                        state_q  <= ISSUE;
                    end
                end
                ISSUE: begin
                    start_q <= 1'b0;
                    state_q <= WAIT_BUSY;
                end
                WAIT_BUSY: begin
                    if (mult_busy_i) begin
                        state_q <= WAIT_DONE;
                    end else if (to_cnt_q == TO_LIM) begin
                        err_q   <= 1'b1;
                        state_q <= IDLE;
                    end else begin
                        to_cnt_q <= to_cnt_q + TO_W'(1);
                    end
                end
                WAIT_DONE: begin
                    if (!mult_busy_i) begin
                        y_q         <= mult_y_bi;
                        ack_q[id_q] <= 1'b1;
                        state_q     <= RESP;
                    end
                end
                RESP: begin
                    state_q <= IDLE;
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign ack_bo       = ack_q;
    assign y_bo         = y_q;
    assign busy_o       = (state_q != IDLE);
    assign err_o        = err_q;
    assign mult_start_o = start_q;
    assign mult_a_bo    = a_q;
    assign mult_b_bo    = b_q;

endmodule

// File: tb/tb_mult_rr_sched.sv
// Bench for mult_rr_sched with a behavioural shift-add multiplier alongside it and
// an edge-timed reference model feeding an expected-ack queue.
module tb_mult_rr_sched;

    localparam int N   = 4;
    localparam int BTO = 4;
    localparam int EW  = 56;

    logic            clk = 1'b0;
    logic            rst_i;
    logic [N-1:0]    req_bi;
    logic [8*N-1:0]  a_bi;
    logic [8*N-1:0]  b_bi;
    logic [N-1:0]    ack_bo;
    logic [15:0]     y_bo;
    logic            busy_o;
    logic            err_o;
    logic            mult_start_o;
    logic [7:0]      mult_a_bo;
    logic [7:0]      mult_b_bo;
    logic [15:0]     mult_y_bi;
    logic            mult_busy_i;

    int tests_run = 0;
    int failed    = 0;

    // ---------------- clock / reset ----------------
    always #5 clk = ~clk;

    mult_rr_sched #(
        .N_REQ   (N),
        .BUSY_TO (BTO)
    ) dut (
        .clk_i        (clk),
        .rst_i        (rst_i),
        .req_bi       (req_bi),
        .a_bi         (a_bi),
        .b_bi         (b_bi),
        .ack_bo       (ack_bo),
        .y_bo         (y_bo),
        .busy_o       (busy_o),
        .err_o        (err_o),
        .mult_start_o (mult_start_o),
        .mult_a_bo    (mult_a_bo),
        .mult_b_bo    (mult_b_bo),
        .mult_y_bi    (mult_y_bi),
        .mult_busy_i  (mult_busy_i)
    );

    // ---------------- external 8x8 shift-add multiplier ----------------
    logic        m_busy;
    logic [3:0]  m_cnt;
    logic [15:0] m_acc;
    logic [15:0] m_sh;
    logic [7:0]  m_b;
    logic        dead = 1'b0;

    always @(posedge clk) begin
        if (rst_i) begin
            m_busy <= 1'b0;
            m_cnt  <= 4'd0;
            m_acc  <= 16'd0;
            m_sh   <= 16'd0;
            m_b    <= 8'd0;
        end else if (mult_start_o) begin
            m_busy <= 1'b1;
            m_cnt  <= 4'd0;
            m_acc  <= 16'd0;
            m_sh   <= {8'd0, mult_a_bo};
            m_b    <= mult_b_bo;
        end else if (m_busy) begin
            if (m_cnt == 4'd8) begin
                m_busy <= 1'b0;
            end else begin
                if (m_b[0]) m_acc <= m_acc + m_sh;
                m_sh  <= m_sh << 1;
                m_b   <= m_b >> 1;
                m_cnt <= m_cnt + 4'd1;
            end
        end
    end

    assign mult_y_bi   = m_acc;
    assign mult_busy_i = m_busy & ~dead;

    // ---------------- reference model ----------------
    // Service rules in edge numbers: a grant at edge g acks at g+11 and frees the
    // scheduler for a new sample at g+13; with a dead multiplier err rises at g+BTO+2.
    logic [EW-1:0] exp_q[$];
    int            e       = 0;
    int            free_at = 0;
    int            mptr    = N - 1;
    int            g       = -100;
    int            g_end   = -1;
    int            w;
    int            c;
    bit            op_live = 1'b0;
    bit            g_dead  = 1'b0;
    bit            mon_en  = 1'b0;
    logic [7:0]    cur_a   = 8'd0;
    logic [7:0]    cur_b   = 8'd0;
    logic [15:0]   y_exp   = 16'd0;
    logic [15:0]   prod;
    bit            err_exp   = 1'b0;
    bit            exp_busy  = 1'b0;
    bit            exp_start = 1'b0;

    always @(posedge clk) begin
        e++;
        if (rst_i) begin
            free_at = e + 1;
            mptr    = N - 1;
            op_live = 1'b0;
            g       = -100;
            g_end   = -1;
            cur_a   = 8'd0;
            cur_b   = 8'd0;
            y_exp   = 16'd0;
            err_exp = 1'b0;
            exp_q.delete();
            mon_en  = 1'b1;
        end else begin
            if (op_live && !g_dead && e == g + 11) y_exp = 16'(cur_a) * 16'(cur_b);
            if (op_live && g_dead && e == g + BTO + 2) err_exp = 1'b1;
            if (e >= free_at && req_bi != '0) begin
                w = -1;
                for (int k = 1; k <= N; k++) begin
                    c = (mptr + k) % N;
                    if (w < 0 && req_bi[c]) w = c;
                end
                mptr    = w;
                g       = e;
                op_live = 1'b1;
                g_dead  = dead;
                cur_a   = a_bi[w*8 +: 8];
                cur_b   = b_bi[w*8 +: 8];
                if (dead) begin
                    g_end   = e + BTO + 1;
                    free_at = e + BTO + 3;
                end else begin
                    g_end   = e + 11;
                    free_at = e + 13;
                    prod    = 16'(cur_a) * 16'(cur_b);
                    exp_q.push_back({32'(e + 11), 8'(w), prod});
                end
            end
        end
        exp_busy  = op_live && e >= g && e <= g_end;
        exp_start = op_live && e == g;
    end

    // ---------------- scoreboard / monitor ----------------
    int            ack_log[$];
    int            ack_edge[$];
    logic [EW-1:0] mon_ent;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp_v);
        tests_run++;
        if (act !== exp_v) begin
            failed++;
            $display("FAIL %s: got %0h, expected %0h (edge %0d)", name, act, exp_v, e);
        end
    endtask

    function automatic int oh_idx(input logic [N-1:0] v);
        int r = -1;
        for (int i = 0; i < N; i++) if (v[i] && r < 0) r = i;
        return r;
    endfunction

    always @(negedge clk) begin
        if (mon_en) begin
            check("busy_o", 32'(busy_o), 32'(exp_busy));
            check("err_o", 32'(err_o), 32'(err_exp));
            check("mult_start_o", 32'(mult_start_o), 32'(exp_start));
            check("y_bo_hold", 32'(y_bo), 32'(y_exp));
            check("mult_a_bo", 32'(mult_a_bo), 32'(cur_a));
            check("mult_b_bo", 32'(mult_b_bo), 32'(cur_b));
            if (ack_bo != '0) begin
                ack_log.push_back(oh_idx(ack_bo));
                ack_edge.push_back(e);
                if (exp_q.size() == 0) begin
                    check("unexpected_ack", 32'(ack_bo), 32'd0);
                end else begin
                    mon_ent = exp_q.pop_front();
                    check("ack_onehot", 32'(ack_bo), 32'(1) << mon_ent[23:16]);
                    check("ack_y", 32'(y_bo), 32'(mon_ent[15:0]));
                    check("ack_edge", 32'(e), mon_ent[55:24]);
                end
            end else if (exp_q.size() > 0) begin
                mon_ent = exp_q[0];
                if (int'(mon_ent[55:24]) <= e) begin
                    void'(exp_q.pop_front());
                    check("ack_missing", 32'(ack_bo), 32'(1) << mon_ent[23:16]);
                end
            end
        end
    end

    // ---------------- driver ----------------
    bit         pend[N];
    bit         rearm[N];
    logic [7:0] av[N];
    logic [7:0] bv[N];

    task automatic drive();
        for (int i = 0; i < N; i++) begin
            req_bi[i]       = pend[i];
            a_bi[i*8 +: 8]  = av[i];
            b_bi[i*8 +: 8]  = bv[i];
        end
    endtask

    task automatic rand_ops(input int i);
        int sel;
        sel = $urandom_range(0, 7);
        case (sel)
            0:       begin av[i] = 8'hFF; bv[i] = 8'hFF; end
            1:       begin av[i] = 8'h00; bv[i] = 8'($urandom); end
            2:       begin av[i] = 8'($urandom); bv[i] = 8'h01; end
            default: begin av[i] = 8'($urandom); bv[i] = 8'($urandom); end
        endcase
        pend[i] = 1'b1;
    endtask

    // One negedge: requesters react to their ack, then inputs are re-driven.
    task automatic next();
        @(negedge clk);
        for (int i = 0; i < N; i++) begin
            if (ack_bo[i] === 1'b1) begin
                if (rearm[i]) rand_ops(i);
                else pend[i] = 1'b0;
            end
        end
        drive();
    endtask

    task automatic raise(input int i, input logic [7:0] a, input logic [7:0] b);
        pend[i] = 1'b1;
        av[i]   = a;
        bv[i]   = b;
        drive();
    endtask

    function automatic bit any_pend();
        bit r = 1'b0;
        for (int i = 0; i < N; i++) r |= pend[i];
        return r;
    endfunction

    task automatic do_reset();
        for (int i = 0; i < N; i++) begin
            pend[i]  = 1'b0;
            rearm[i] = 1'b0;
        end
        drive();
        rst_i = 1'b1;
        next();
        next();
        rst_i = 1'b0;
    endtask

    task automatic wait_drain(input string name, input int max_cyc);
        int n = 0;
        while ((exp_q.size() != 0 || any_pend() || exp_busy) && n < max_cyc) begin
            next();
            n++;
        end
        if (n >= max_cyc) begin
            tests_run++;
            failed++;
            $display("FAIL %s_drain: not idle after %0d cycles", name, n);
        end
    endtask

    function automatic int log_id(input int k);
        return (k < ack_log.size()) ? ack_log[k] : -1;
    endfunction

    function automatic int log_edge(input int k);
        return (k < ack_edge.size()) ? ack_edge[k] : -1;
    endfunction

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- stimulus ----------------
    initial begin
        int s_edge;
        int err_edge;
        int n;

        for (int i = 0; i < N; i++) begin
            pend[i] = 1'b0; rearm[i] = 1'b0; av[i] = 8'd0; bv[i] = 8'd0;
        end
        drive();
        rst_i = 1'b1;
        next();
        next();
        rst_i = 1'b0;

        check("rst_ack", 32'(ack_bo), 32'd0);
        check("rst_y", 32'(y_bo), 32'd0);
        check("rst_busy", 32'(busy_o), 32'd0);
        check("rst_err", 32'(err_o), 32'd0);
        check("rst_start", 32'(mult_start_o), 32'd0);
        check("rst_mult_a", 32'(mult_a_bo), 32'd0);
        check("rst_mult_b", 32'(mult_b_bo), 32'd0);

        // single request
        ack_log.delete(); ack_edge.delete();
        s_edge = e + 1;
        raise(2, 8'd13, 8'd11);
        wait_drain("single", 100);
        check("single_cnt", 32'(ack_log.size()), 32'd1);
        check("single_id", 32'(log_id(0)), 32'd2);
        check("single_lat", 32'(log_edge(0) - s_edge), 32'd11);
        check("single_y", 32'(y_bo), 32'd143);

        // corner operands
        raise(1, 8'hFF, 8'hFF);
        wait_drain("corner_ff", 100);
        check("corner_ff_y", 32'(y_bo), 32'hFE01);
        raise(1, 8'h00, 8'hA5);
        wait_drain("corner_zero", 100);
        check("corner_zero_y", 32'(y_bo), 32'd0);

        // all four requesting from reset, continuously re-asserted
        do_reset();
        ack_log.delete(); ack_edge.delete();
        for (int i = 0; i < N; i++) begin
            rearm[i] = 1'b1;
            rand_ops(i);
        end
        drive();
        n = 0;
        while (ack_log.size() < 5 && n < 200) begin
            next();
            n++;
        end
        for (int i = 0; i < N; i++) rearm[i] = 1'b0;
        wait_drain("all4", 200);
        for (int k = 0; k < 5; k++) check("all4_order", 32'(log_id(k)), 32'(k % N));
        for (int k = 0; k < 4; k++) check("all4_gap", 32'(log_edge(k + 1) - log_edge(k)), 32'd13);

        // wrap-around: 3 served, 1 pending, 0 raised during service
        do_reset();
        ack_log.delete(); ack_edge.delete();
        raise(3, 8'd7, 8'd5);
        next();
        raise(1, 8'd3, 8'd9);
        next(); next(); next();
        raise(0, 8'd200, 8'd2);
        wait_drain("wrap", 200);
        check("wrap_first", 32'(log_id(0)), 32'd3);
        check("wrap_second", 32'(log_id(1)), 32'd0);
        check("wrap_third", 32'(log_id(2)), 32'd1);

        // reset during WAIT_DONE drops the in-flight request
        ack_log.delete(); ack_edge.delete();
        raise(2, 8'd21, 8'd3);
        for (int k = 0; k < 5; k++) next();
        for (int i = 0; i < N; i++) pend[i] = 1'b0;
        drive();
        rst_i = 1'b1;
        next();
        rst_i = 1'b0;
        check("midrst_ack", 32'(ack_bo), 32'd0);
        check("midrst_y", 32'(y_bo), 32'd0);
        check("midrst_busy", 32'(busy_o), 32'd0);
        check("midrst_start", 32'(mult_start_o), 32'd0);
        check("midrst_mult_a", 32'(mult_a_bo), 32'd0);
        raise(2, 8'd4, 8'd4);
        raise(0, 8'd6, 8'd7);
        wait_drain("midrst", 200);
        check("midrst_no_stale_ack", 32'(ack_log.size()), 32'd2);
        check("midrst_first", 32'(log_id(0)), 32'd0);

        // randomized traffic
        for (int cyc = 0; cyc < 400; cyc++) begin
            next();
            for (int i = 0; i < N; i++) begin
                if (!pend[i] && $urandom_range(0, 3) == 0) rand_ops(i);
            end
            drive();
        end
        wait_drain("random", 400);

        // withdrawal after grant still yields an ack
        ack_log.delete(); ack_edge.delete();
        raise(1, 8'd7, 8'd9);
        next(); next(); next();
        pend[1] = 1'b0;
        drive();
        wait_drain("withdraw", 100);
        check("withdraw_id", 32'(log_id(0)), 32'd1);
        check("withdraw_y", 32'(y_bo), 32'd63);

        // busy timeout with a dead multiplier
        ack_log.delete(); ack_edge.delete();
        dead = 1'b1;
        err_edge = -1;
        s_edge = e + 1;
        raise(2, 8'd3, 8'd4);
        for (int k = 0; k < 30; k++) begin
            next();
            if (err_o === 1'b1 && err_edge < 0) err_edge = e;
        end
        pend[2] = 1'b0;
        drive();
        for (int k = 0; k < 20; k++) next();
        check("to_err_edge", 32'(err_edge - s_edge), 32'(BTO + 2));
        check("to_err_sticky", 32'(err_o), 32'd1);
        check("to_no_ack", 32'(ack_log.size()), 32'd0);
        check("to_idle", 32'(busy_o), 32'd0);
        dead = 1'b0;
        do_reset();
        check("to_err_cleared", 32'(err_o), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests_run, failed);
        $finish;
    end

endmodule
